// File: rtl/mem_copy_master_if.sv
// Bambu minimal memory channel (Mout_*/M_* set) between a copy master and a memory responder.
interface mem_copy_master_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int SIZE_W = 4
);
  logic              Mout_oe_ram;
  logic              Mout_we_ram;
  logic [ADDR_W-1:0] Mout_addr_ram;
  logic [DATA_W-1:0] Mout_Wdata_ram;
  logic [SIZE_W-1:0] Mout_data_ram_size;
  logic [DATA_W-1:0] M_Rdata_ram;
  logic              M_DataRdy;

  modport master (
    output Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
    input  M_Rdata_ram, M_DataRdy
  );

  modport slave (
    input  Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
    output M_Rdata_ram, M_DataRdy
  );
endinterface

// File: rtl/mem_copy_master.sv
// Forward block-copy master: alternating read/write requests on one Bambu memory channel.
// Optional MEM_COPY_TIMEOUT_EN adds a per-request wait limit (WAIT_MAX) with an ERR state.
module mem_copy_master #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int SIZE_W   = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done_port,
  output logic              err,
  mem_copy_master_if.master mem
);
  typedef enum logic [2:0] {
    IDLE, RD, WR, DONE
`ifdef MEM_COPY_TIMEOUT_EN
    , ERR
`endif
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W:0]   idx, idx_n, len_q;
  logic [ADDR_W-1:0] src_q, dst_q, addr_q;
  logic [DATA_W-1:0] data_q;
  logic              rdy, accept;

  assign rdy    = mem.M_DataRdy;
  assign accept = (state == IDLE) && start;

`ifdef MEM_COPY_TIMEOUT_EN
  logic [7:0] wcnt;
  logic       expired, err_q;
  assign expired = (wcnt == 8'(WAIT_MAX - 1));
  assign err     = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      IDLE: if (start) begin
        idx_n   = '0;
        state_n = (len == '0) ? DONE : RD;
      end
      RD: if (rdy) state_n = WR;
`ifdef MEM_COPY_TIMEOUT_EN
          else if (expired) state_n = ERR;
`endif
      WR: if (rdy) begin
        idx_n   = idx + 1'b1;
        state_n = (idx + 1'b1 == len_q) ? DONE : RD;
      end
`ifdef MEM_COPY_TIMEOUT_EN
          else if (expired) state_n = ERR;
      ERR:  state_n = DONE;
`endif
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      len_q  <= '0;
      src_q  <= '0;
      dst_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (accept) begin
        src_q <= src_addr;
        dst_q <= dst_addr;
        len_q <= len;
      end
      // address is registered for the state being entered; src_q is not loaded yet on accept
      if (state_n == RD)
        addr_q <= ((state == IDLE) ? src_addr : src_q) + idx_n[ADDR_W-1:0];
      else if (state_n == WR)
        addr_q <= dst_q + idx_n[ADDR_W-1:0];
      if (state == RD && rdy) data_q <= mem.M_Rdata_ram;
    end
  end

`ifdef MEM_COPY_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_n != state)               wcnt <= '0;
      else if (state == RD || state == WR) wcnt <= wcnt + 8'd1;
      if (accept)               err_q <= 1'b0;
      else if (state_n == ERR)  err_q <= 1'b1;
    end
  end
`endif

  assign busy                   = (state != IDLE);
  assign done_port              = (state == DONE);
  assign mem.Mout_oe_ram        = (state == RD);
  assign mem.Mout_we_ram        = (state == WR);
  assign mem.Mout_addr_ram      = addr_q;
  assign mem.Mout_Wdata_ram     = data_q;
  assign mem.Mout_data_ram_size = SIZE_W'(DATA_W);
endmodule

// File: tb/tb_mem_copy_master.sv
// Bench for mem_copy_master: behavioural memory responder (read delay 2, write delay 1),
// table vectors, hand sequences for corner cases, and randomized copies against a forward-copy model.
module tb_mem_copy_master;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int SW = 4;
  localparam int MS = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [AW:0]   len = '0;
  logic          busy, done_port, err;

  mem_copy_master_if #(.ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW)) bus ();

  mem_copy_master #(.ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW), .WAIT_MAX(15)) dut (
    .clock(clock), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .busy(busy), .done_port(done_port), .err(err), .mem(bus)
  );

  always #5 clock = ~clock;

  // ---------------- responder and bus monitor ----------------
  logic [DW-1:0] mem_arr  [MS];
  logic [DW-1:0] init_mem [MS];
  logic [DW-1:0] ref_mem  [MS];
  logic          mon_clr = 1'b0;
  logic          hang = 1'b0;
  int            stall_rd = -1, stall_n = 0;
  int            cnt, rd_done, both_hi, unstable, strobe_cyc, n_rd, n_wr;
  logic [AW-1:0] rd_log [8];
  logic [AW-1:0] wr_log [8];
  logic          held;
  logic          h_oe, h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wd;

  always_comb begin
    bus.M_DataRdy = 1'b0;
    if (!hang) begin
      if (bus.Mout_oe_ram)      bus.M_DataRdy = (cnt >= 1 + ((rd_done == stall_rd) ? stall_n : 0));
      else if (bus.Mout_we_ram) bus.M_DataRdy = 1'b1;
    end
  end
  assign bus.M_Rdata_ram = mem_arr[bus.Mout_addr_ram];

  always @(posedge clock) begin
    if (mon_clr) begin
      mem_arr <= init_mem;
      cnt <= 0; rd_done <= 0; both_hi <= 0; unstable <= 0; strobe_cyc <= 0;
      n_rd <= 0; n_wr <= 0; held <= 1'b0;
    end else begin
      if (!(bus.Mout_oe_ram || bus.Mout_we_ram) || bus.M_DataRdy) cnt <= 0;
      else cnt <= cnt + 1;
      if (bus.Mout_oe_ram && bus.Mout_we_ram) both_hi <= both_hi + 1;
      if (bus.Mout_oe_ram || bus.Mout_we_ram) strobe_cyc <= strobe_cyc + 1;
      if (bus.Mout_oe_ram && bus.M_DataRdy) begin
        if (n_rd < 8) rd_log[n_rd[2:0]] <= bus.Mout_addr_ram;
        n_rd    <= n_rd + 1;
        rd_done <= rd_done + 1;
      end
      if (bus.Mout_we_ram && bus.M_DataRdy) begin
        mem_arr[bus.Mout_addr_ram] <= bus.Mout_Wdata_ram;
        if (n_wr < 8) wr_log[n_wr[2:0]] <= bus.Mout_addr_ram;
        n_wr <= n_wr + 1;
      end
      if (held && (bus.Mout_oe_ram != h_oe || bus.Mout_we_ram != h_we ||
                   bus.Mout_addr_ram != h_addr || (h_we && bus.Mout_Wdata_ram != h_wd)))
        unstable <= unstable + 1;
      held   <= (bus.Mout_oe_ram || bus.Mout_we_ram) && !bus.M_DataRdy;
      h_oe   <= bus.Mout_oe_ram;
      h_we   <= bus.Mout_we_ram;
      h_addr <= bus.Mout_addr_ram;
      h_wd   <= bus.Mout_Wdata_ram;
    end
  end

  // ---------------- checking helpers ----------------
  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model(input int s, input int d, input int l);
    for (int i = 0; i < MS; i++) ref_mem[i] = init_mem[i];
    for (int i = 0; i < l; i++) ref_mem[(d + i) % MS] = ref_mem[(s + i) % MS];
  endtask

  task automatic chk_mem(input string name);
    int bad = 0;
    for (int i = 0; i < MS; i++) if (mem_arr[i] !== ref_mem[i]) bad++;
    chk(name, bad, 0);
  endtask

  task automatic rand_init();
    for (int i = 0; i < MS; i++) init_mem[i] = DW'($urandom_range(0, 255));
  endtask

  task automatic pulse_clr();
    @(negedge clock); mon_clr = 1'b1;
    @(negedge clock); mon_clr = 1'b0;
  endtask

  // returns done_port cycle (start sampled at edge 0), or -1 if it never came
  task automatic run_copy(input int s, input int d, input int l, output int dc);
    pulse_clr();
    src_addr = AW'(s); dst_addr = AW'(d); len = (AW+1)'(l); start = 1'b1;
    @(negedge clock); start = 1'b0; dc = 1;
    if (l != 0) chk("busy_cycle1", busy, 1);
    while (done_port !== 1'b1 && dc < 3 * l + 60) begin @(negedge clock); dc++; end
    if (done_port !== 1'b1) dc = -1;
    @(negedge clock);
    chk("done_single_cycle", done_port, 0);
    chk("busy_idle_after", busy, 0);
  endtask

  typedef struct {
    int s, d, l;
    int exp_done;
    int exp_strobes;
  } vec_t;

  function automatic vec_t mk(input int s, input int d, input int l, input int e, input int st);
    vec_t v;
    v.s = s; v.d = d; v.l = l; v.exp_done = e; v.exp_strobes = st;
    return v;
  endfunction

  vec_t tbl [5];
  int   dc;
  logic saw;

  initial begin
    tbl[0] = mk(0,   8,   4,   13,  12);
    tbl[1] = mk(20,  40,  0,   1,   0);
    tbl[2] = mk(5,   100, 1,   4,   3);
    tbl[3] = mk(126, 0,   3,   10,  9);
    tbl[4] = mk(3,   70,  128, 385, 384);

    for (int i = 0; i < MS; i++) init_mem[i] = '0;

    // reset state
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done_port, 0);
    chk("rst_err", err, 0);
    chk("rst_oe", bus.Mout_oe_ram, 0);
    chk("rst_we", bus.Mout_we_ram, 0);
    chk("rst_addr", bus.Mout_addr_ram, 0);
    chk("rst_wdata", bus.Mout_Wdata_ram, 0);
    chk("size_const", bus.Mout_data_ram_size, DW);
    @(negedge clock); @(negedge clock); reset = 1'b0;

    // table vectors on random memory contents
    for (int t = 0; t < 5; t++) begin
      rand_init();
      model(tbl[t].s, tbl[t].d, tbl[t].l);
      run_copy(tbl[t].s, tbl[t].d, tbl[t].l, dc);
      chk("tbl_done_cycle", dc, tbl[t].exp_done);
      chk("tbl_strobe_cycles", strobe_cyc, tbl[t].exp_strobes);
      chk("tbl_both_high", both_hi, 0);
      chk_mem("tbl_memory");
    end

    // basic copy with fixed values
    for (int i = 0; i < MS; i++) init_mem[i] = '0;
    init_mem[0] = 8'd11; init_mem[1] = 8'd22; init_mem[2] = 8'd33; init_mem[3] = 8'd44;
    run_copy(0, 8, 4, dc);
    chk("basic_done_cycle", dc, 13);
    chk("basic_m8", mem_arr[8], 11);
    chk("basic_m9", mem_arr[9], 22);
    chk("basic_m10", mem_arr[10], 33);
    chk("basic_m11", mem_arr[11], 44);

    // wrap-around with forward-copy replication
    init_mem[126] = 8'hA5; init_mem[127] = 8'h5A; init_mem[0] = 8'h77;
    run_copy(126, 0, 3, dc);
    chk("wrap_rd0", rd_log[0], 126);
    chk("wrap_rd1", rd_log[1], 127);
    chk("wrap_rd2", rd_log[2], 0);
    chk("wrap_wr0", wr_log[0], 0);
    chk("wrap_wr1", wr_log[1], 1);
    chk("wrap_wr2", wr_log[2], 2);
    chk("wrap_m0", mem_arr[0], 8'hA5);
    chk("wrap_m1", mem_arr[1], 8'h5A);
    chk("wrap_m2", mem_arr[2], 8'hA5);

    // stalled second read
    rand_init();
    model(10, 50, 3);
    stall_rd = 1; stall_n = 5;
    run_copy(10, 50, 3, dc);
    stall_rd = -1; stall_n = 0;
    chk("stall_done_cycle", dc, 15);
    chk("stall_unstable", unstable, 0);
    chk("stall_both_high", both_hi, 0);
    chk_mem("stall_memory");

    // asynchronous reset mid-copy
    rand_init();
    pulse_clr();
    src_addr = 7'd30; dst_addr = 7'd90; len = 8'd4; start = 1'b1;
    @(negedge clock); start = 1'b0;
    chk("midrst_oe_before", bus.Mout_oe_ram, 1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_oe", bus.Mout_oe_ram, 0);
    chk("midrst_we", bus.Mout_we_ram, 0);
    chk("midrst_done", done_port, 0);
    @(negedge clock); @(negedge clock); reset = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 15; i++) begin @(negedge clock); if (done_port) saw = 1'b1; end
    chk("midrst_no_done", saw, 0);
    model(30, 90, 4);
    run_copy(30, 90, 4, dc);
    chk("midrst_next_done", dc, 13);
    chk_mem("midrst_next_memory");

`ifdef MEM_COPY_TIMEOUT_EN
    // responder never answers
    hang = 1'b1;
    run_copy(0, 64, 2, dc);
    chk("tmo_done_cycle", dc, 17);
    chk("tmo_rd_cycles", strobe_cyc, 15);
    chk("tmo_err_set", err, 1);
    repeat (3) @(negedge clock);
    chk("tmo_err_sticky", err, 1);
    hang = 1'b0;
    rand_init();
    model(0, 64, 2);
    run_copy(0, 64, 2, dc);
    chk("tmo_err_cleared", err, 0);
    chk("tmo_next_done", dc, 7);
    chk_mem("tmo_next_memory");
`endif

    // randomized copies against the model
    for (int r = 0; r < 12; r++) begin
      int s, d, l;
      s = $urandom_range(0, MS - 1);
      d = $urandom_range(0, MS - 1);
      l = $urandom_range(1, 20);
      rand_init();
      model(s, d, l);
      run_copy(s, d, l, dc);
      chk("rand_done_cycle", dc, 3 * l + 1);
      chk("rand_unstable", unstable, 0);
      chk_mem("rand_memory");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_copy_master.md
# mem_copy_master

Synthesizable block-copy initiator for one channel of the Bambu minimal memory interface (Mout_*/M_* signal set). On a start pulse it copies `len` consecutive data words from `src_addr` to `dst_addr` by issuing alternating read and write requests. It waits for `M_DataRdy` on every request. It sits where an HLS `main` master would sit and drives the same off-chip memory responder used in simulation, so the memory model and the board memory controller can be exercised without an HLS-generated core.

## Interface
- ADDR_W, 7, word address width per channel.
- DATA_W, 8, data width per channel; driven on `Mout_data_ram_size` as a constant.
- SIZE_W, 4, width of the size field.
- WAIT_MAX, 15, maximum cycles to wait for `M_DataRdy` per request; used only with the timeout macro.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a copy; sampled only in IDLE.
- src_addr  in  ADDR_W  first source address; sampled with `start`.
- dst_addr  in  ADDR_W  first destination address; sampled with `start`.
- len  in  ADDR_W+1  number of words to copy; sampled with `start`.
- busy  out  1  high from the cycle after `start` is accepted until `done_port` is high.
- done_port  out  1  one-cycle completion pulse.
- err  out  1  sticky timeout flag; cleared when the next `start` is accepted.
- Mout_oe_ram  out  1  read strobe.
- Mout_we_ram  out  1  write strobe.
- Mout_addr_ram  out  ADDR_W  request address.
- Mout_Wdata_ram  out  DATA_W  write data.
- Mout_data_ram_size  out  SIZE_W  access size in bits; constant DATA_W.
- M_Rdata_ram  in  DATA_W  read data; valid in any cycle where `M_DataRdy` is high during a read.
- M_DataRdy  in  1  request-complete indication from the responder.

## Operation
- Reset values:
  - State is IDLE; index and wait counter are 0.
  - `busy`, `done_port`, `err`, `Mout_oe_ram`, `Mout_we_ram` are 0.
  - `Mout_addr_ram` and `Mout_Wdata_ram` are 0.
- All outputs are registered, or decoded from the state register only.
- States:
  - IDLE: strobes low. When `start` is high, latch `src_addr`, `dst_addr` and `len`, clear `err`, set idx=0. If len==0 go to DONE, otherwise go to RD.
  - RD: `Mout_oe_ram`=1, `Mout_addr_ram`=src+idx (mod 2^ADDR_W). On a rising edge with `M_DataRdy`=1, capture `M_Rdata_ram` into the data register and go to WR.
  - WR: `Mout_we_ram`=1, `Mout_addr_ram`=dst+idx (mod 2^ADDR_W), `Mout_Wdata_ram`=captured data. On `M_DataRdy`=1, increment idx. Go to DONE if idx+1==len, otherwise go to RD.
  - DONE: `done_port`=1 for exactly one cycle, then IDLE.
  - ERR (timeout builds only): strobes low, `err`=1, then DONE.
- `Mout_oe_ram` and `Mout_we_ram` are never high in the same cycle.
- Address, data and size are held stable while a strobe is high and `M_DataRdy` has not yet been sampled high.
- The copy runs forward only. For overlapping regions with src<dst, earlier words are replicated; this is the required behaviour.
- Address arithmetic wraps modulo 2^ADDR_W. A copy with len=2^ADDR_W touches every address once.
- `start` is ignored while not in IDLE. `start` in the same cycle as `done_port` is also ignored.
- `M_DataRdy` is ignored in IDLE and in DONE.
- Reset asserted mid-copy immediately drops both strobes. No partial `done_port` is issued.

## Timing
- Request issue: a strobe rises in the cycle after the state is entered. Back-to-back requests are allowed with no idle cycle between WR and the next RD.
- With the standard responder (read delay 2, write delay 1), each word takes 3 cycles: 2 for the read, 1 for the write.
- If `start` is sampled at edge 0, `done_port` is high in cycle 3·len+1. For len=0 it is high in cycle 1.
- The read-data capture and the state change happen on the same edge that samples `M_DataRdy`=1.

## Configuration
- MEM_COPY_TIMEOUT_EN:
  - Defined: an 8-bit wait counter resets on every state entry and increments each cycle in RD or WR. When it reaches WAIT_MAX without `M_DataRdy`, the FSM goes to ERR. The current and remaining words are abandoned.
  - Undefined: the FSM waits indefinitely, `err` is tied to 0, and the ERR state and counter are not built.

## Test plan
- Reset mid-copy: assert `reset` asynchronously while `Mout_oe_ram`=1. Both strobes must read 0 before the next edge, with no `done_port`. The next `start` copies normally.
- Basic copy: memory[0..3]=11,22,33,44; start with src=0, dst=8, len=4. memory[8..11] must equal 11,22,33,44, and `done_port` must pulse in cycle 13.
- Zero length: start with len=0. `done_port` pulses in cycle 1 with no strobe activity.
- Wrap-around: ADDR_W=7, src=126, dst=0, len=3. Reads go to 126, 127, 0; writes go to 0, 1, 2. Write 0 happens before read 0, so dst[2] receives the value already written to dst[0] (forward-copy replication).
- Stalled responder: hold `M_DataRdy`=0 for 5 extra cycles on the second read. `Mout_addr_ram` and `Mout_oe_ram` stay stable for the whole stall, `done_port` arrives 5 cycles late, and `Mout_oe_ram` and `Mout_we_ram` are never both high.
- Timeout (macro defined, WAIT_MAX=15): tie `M_DataRdy`=0. ERR is entered after 15 RD cycles; `err`=1 and stays set, `done_port` pulses once, and the next `start` clears `err`.
